// File: rtl/queue_pkg.sv
// Shared types and constants for the queue write-side front end.
package queue_pkg;

  localparam int DATA_W = 4;   // switch / queue word width
  localparam int DEPTH  = 8;   // queue depth, ceiling of the occupancy mirror
  localparam int CNT_W  = 4;   // occupancy mirror width, holds 0..DEPTH

  // Button-handling states: debounce the press, strobe once, wait for a clean release.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    PUSH     = 3'd2,
    HOLD     = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  // Width of a counter that has to reach n-1; never narrower than one bit.
  function automatic int dbc_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw push button.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two stages give the first flop a full cycle to settle before q is used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/queue_writer.sv
// Write-side front end: one debounced press becomes one write strobe, with
// overflow tracking under backpressure and an occupancy mirror of the queue.
module queue_writer
  import queue_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              q_full,
  input  logic              q_pop,
  input  logic              clr_ovf,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              overflow,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  localparam int               DBC_W    = dbc_width(DB_CYCLES);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  state_t           state;
  logic [DBC_W-1:0] dbc;
  logic             btn_s;

  btn_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_s)
  );

  // The strobe is a pure decode of PUSH so it can never last more than one cycle.
  assign wr_en = (state == PUSH) && !q_full;
  assign busy  = (state != IDLE);

  // Press/release FSM; dbc restarts on every state change, data is captured on entry to PUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dbc     <= '0;
      wr_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_DB;
            dbc   <= '0;
          end
        end
        PRESS_DB: begin
          if (!btn_s) begin
            state <= IDLE;
            dbc   <= '0;
          end else if (dbc == DBC_LAST) begin
            state   <= PUSH;
            dbc     <= '0;
            wr_data <= data_in;
          end else begin
            dbc <= dbc + 1'b1;
          end
        end
        PUSH: begin
          state <= HOLD;
          dbc   <= '0;
        end
        HOLD: begin
          if (!btn_s) begin
            state <= REL_DB;
            dbc   <= '0;
          end
        end
        REL_DB: begin
          if (btn_s) begin
            state <= HOLD;
            dbc   <= '0;
          end else if (dbc == DBC_LAST) begin
            state <= IDLE;
            dbc   <= '0;
          end else begin
            dbc <= dbc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dbc   <= '0;
        end
      endcase
    end
  end

  // Occupancy mirror: a write and a pop in the same cycle cancel; clamps at 0 and DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_en && !q_pop) begin
      if (count != CNT_MAX) count <= count + 1'b1;
    end else if (q_pop && !wr_en) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (state == PUSH && q_full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
